// File: rtl/mem_access_unit.sv
// MEM-stage access unit: issues one cache/DMA request per memory op,
// stalls the pipeline until the ack, then returns aligned load data.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_cache_i,
  input  logic        valid_dma_i,
  input  logic        mem_rw_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        cache_req_valid_o,
  input  logic        cache_req_ready_i,
  input  logic        cache_rsp_valid_i,
  input  logic [31:0] cache_rdata_i,
  output logic        dma_req_valid_o,
  input  logic        dma_req_ready_i,
  input  logic        dma_rsp_valid_i,
  input  logic [31:0] dma_rdata_i,
  output logic        req_rw_o,
  output logic [31:0] req_addr_o,
  output logic [31:0] req_wdata_o,
  output logic [3:0]  req_wstrb_o,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        load_valid_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic             r_tgt_dma;
  logic             r_rw;
  logic [31:0]      r_addr;
  logic [1:0]       r_off;
  logic [2:0]       r_f3;
  logic [31:0]      r_wdata;
  logic [3:0]       r_strb;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_load_data;
  logic             r_err;

  logic             w_any;
  logic             w_legal;
  logic             w_misalign;
  logic             w_accept;
  logic             w_bad;
  logic [1:0]       w_off;
  logic [3:0]       w_strb;
  logic [31:0]      w_wrep;
  logic             w_ready;
  logic             w_rsp;
  logic [31:0]      w_rdata;
  logic [31:0]      w_sh;
  logic [7:0]       w_b;
  logic [15:0]      w_h;
  logic [31:0]      w_ext;
  logic             w_capture;
  logic             w_timeout;
  logic [CNT_W-1:0] w_cnt_inc;

  // Decode legality, strobes and replicated store data of the incoming op
  always_comb begin
    w_any      = valid_cache_i | valid_dma_i;
    w_off      = addr_i[1:0];
    w_legal    = 1'b0;
    w_misalign = 1'b0;
    w_strb     = 4'b1111;
    w_wrep     = wdata_i;
    if (mem_rw_i)
      w_legal = (funct3_i == 3'b000) | (funct3_i == 3'b001) |
                (funct3_i == 3'b010);
    else
      w_legal = (funct3_i != 3'b011) & (funct3_i != 3'b110) &
                (funct3_i != 3'b111);
    unique case (funct3_i[1:0])
      2'b00: begin
        w_strb = 4'b0001 << w_off;
        w_wrep = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        w_strb     = 4'b0011 << w_off;
        w_wrep     = {2{wdata_i[15:0]}};
        w_misalign = addr_i[0];
      end
      default: begin
        w_strb     = 4'b1111;
        w_wrep     = wdata_i;
        w_misalign = (addr_i[1:0] != 2'b00);
      end
    endcase
    w_accept = rst_ni & (r_state == S_IDLE) & w_any & w_legal & ~w_misalign;
    w_bad    = (r_state == S_IDLE) & w_any & ~(w_legal & ~w_misalign);
  end

  // Select the active port and extract/extend the returned word
  always_comb begin
    w_ready = r_tgt_dma ? dma_req_ready_i : cache_req_ready_i;
    w_rsp   = r_tgt_dma ? dma_rsp_valid_i : cache_rsp_valid_i;
    w_rdata = r_tgt_dma ? dma_rdata_i : cache_rdata_i;
    w_sh    = w_rdata >> {r_off, 3'b000};
    w_b     = w_sh[7:0];
    w_h     = r_off[1] ? w_rdata[31:16] : w_rdata[15:0];
    unique case (r_f3)
      3'b000:  w_ext = {{24{w_b[7]}}, w_b};
      3'b001:  w_ext = {{16{w_h[15]}}, w_h};
      3'b100:  w_ext = {24'h0, w_b};
      3'b101:  w_ext = {16'h0, w_h};
      default: w_ext = w_rdata;
    endcase
  end

  // Next-state logic; rsp before ready is ignored
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    w_capture   = 1'b0;
    w_cnt_inc   = r_cnt + 1'b1;
    unique case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_REQ;
      S_REQ: begin
        if (w_ready) begin
          w_capture   = w_rsp;
          w_state_nxt = w_rsp ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_rsp) begin
          w_capture   = 1'b1;
          w_state_nxt = S_DONE;
        end else if (TIMEOUT_CYCLES != 0 &&
                     w_cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Request fields, timeout counter, load result and error pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tgt_dma   <= 1'b0;
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_off       <= '0;
      r_f3        <= '0;
      r_wdata     <= '0;
      r_strb      <= '0;
      r_cnt       <= '0;
      r_load_data <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_tgt_dma <= ~valid_cache_i;
        r_rw      <= mem_rw_i;
        r_addr    <= {addr_i[31:2], 2'b00};
        r_off     <= addr_i[1:0];
        r_f3      <= funct3_i;
        r_wdata   <= w_wrep;
        r_strb    <= w_strb;
      end
      if (r_state == S_WAIT) r_cnt <= w_cnt_inc;
      else                   r_cnt <= '0;
      if (w_capture && !r_rw) r_load_data <= w_ext;
      else if (w_timeout)     r_load_data <= '0;
      r_err <= w_bad | (w_accept & valid_cache_i & valid_dma_i) | w_timeout;
    end
  end

  assign cache_req_valid_o = (r_state == S_REQ) & ~r_tgt_dma;
  assign dma_req_valid_o   = (r_state == S_REQ) & r_tgt_dma;
  assign req_rw_o          = r_rw;
  assign req_addr_o        = r_addr;
  assign req_wdata_o       = r_wdata;
  assign req_wstrb_o       = r_strb;
  assign stall_o           = w_accept | (r_state == S_REQ) |
                             (r_state == S_WAIT);
  assign load_data_o       = r_load_data;
  assign load_valid_o      = (r_state == S_DONE) & ~r_rw;
  assign err_o             = r_err;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Receiving end of the execute-stage memory-request signals (valid-to-cache, valid-to-DMA, MemRW) produced by the decode/execute pipeline registers.
- Turns one pipeline memory instruction into a valid/ready request on either the data-cache port or the DMA register port.
- Freezes the pipeline through stall_o until the response arrives, then returns aligned and sign-extended load data toward writeback.
- Sits in the MEM stage between the EX/MEM register and the cache/DMA fabric.

Parameters:
TIMEOUT_CYCLES, 256, max cycles waiting for rsp_valid after request acceptance; 0 disables timeout
CNT_W, 9, width of timeout counter, must hold TIMEOUT_CYCLES

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
valid_cache_i  in  1  EX/MEM instruction targets data cache
valid_dma_i  in  1  EX/MEM instruction targets DMA registers
mem_rw_i  in  1  1=store, 0=load
funct3_i  in  3  RISC-V access size/sign field
addr_i  in  32  effective byte address
wdata_i  in  32  store data (rs2)
cache_req_valid_o  out  1  cache request valid
cache_req_ready_i  in  1  cache accepts request
cache_rsp_valid_i  in  1  cache response/ack
cache_rdata_i  in  32  cache read word
dma_req_valid_o  out  1  DMA request valid
dma_req_ready_i  in  1  DMA accepts request
dma_rsp_valid_i  in  1  DMA response/ack
dma_rdata_i  in  32  DMA read word
req_rw_o  out  1  registered mem_rw, shared by both ports
req_addr_o  out  32  word-aligned address ({addr[31:2],2'b00}), shared
req_wdata_o  out  32  lane-replicated store data, shared
req_wstrb_o  out  4  byte enables (loads: strobes of bytes read)
stall_o  out  1  freeze all upstream pipeline registers (drives enable_i low)
load_data_o  out  32  aligned and extended load result
load_valid_o  out  1  one-cycle pulse; load_data_o valid
err_o  out  1  one-cycle pulse: misaligned, illegal funct3, conflict or timeout

Behaviour:
- Reset: state IDLE; all outputs 0; counter 0; registered fields 0. Reset mid-transaction abandons it immediately with no error pulse, and responses arriving later are ignored.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If valid_cache_i|valid_dma_i and the access is legal: capture target, rw, addr, wdata, strb and funct3; go to REQ. stall_o is asserted combinationally in this same cycle.
  - Both valid_cache_i and valid_dma_i high: cache wins, err_o pulses, request still issued to cache.
  - Illegal funct3 (load 011/110/111, store other than 000/001/010) or misalignment (half with addr[0]=1, word with addr[1:0]!=0): no request, no stall, err_o pulses one cycle, stay in IDLE.
- REQ:
  - Selected req_valid held high. req_* fields stay stable until ready.
  - Ready without rsp goes to WAIT.
  - Ready and rsp in the same cycle go to DONE.
  - rsp before ready is ignored.
- WAIT:
  - Counter increments each cycle. On rsp_valid of the selected port go to DONE.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES: err_o pulses, load_data_o=0, go to IDLE with stall released.
- DONE:
  - stall_o=0 for exactly one cycle. Loads pulse load_valid_o with load_data_o.
  - Then go to IDLE. A new request may be accepted in the following cycle.
- stall_o = (IDLE & accepting) | REQ | WAIT.
- Store strobes: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111. wdata replicated: SB {4{b}}, SH {2{h}}.
- Load extraction: byte lane addr[1:0], half lane addr[1]. LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough. rdata is captured on rsp_valid; load_data_o holds its value until the next load.
- Stores produce no load_valid_o; they complete on the ack.
- The unselected port's req_valid is always 0.

Test Plan:
- LW addr 0x100, cache ready on cycle 1, rsp on cycle 3 with rdata 0xDEADBEEF -> stall_o high for 3 cycles, load_valid_o pulse with 0xDEADBEEF, req_addr_o=0x100, req_wstrb_o=4'hF.
- LB addr 0x203, rdata 0x80AABBCC -> load_data_o=0xFFFFFF80; same access as LBU -> 0x00000080.
- SH addr 0x12, wdata 0x0000ABCD to DMA, dma_req_ready_i held low 4 cycles -> dma_req_valid_o stable for 5 cycles, req_wdata_o=0xABCDABCD, req_wstrb_o=4'b1100, cache_req_valid_o=0, no load_valid_o.
- LW addr 0x102 -> err_o one-cycle pulse, no request, stall_o never high; same with funct3=3'b011.
- TIMEOUT_CYCLES=8, request accepted, no rsp -> err_o pulse after 8 WAIT cycles, stall_o drops, a late rsp is ignored; then rst_ni low mid-REQ -> all outputs 0 immediately.
- valid_cache_i and valid_dma_i both high -> err_o pulse, only cache_req_valid_o asserted, transaction completes normally.
